// File: rtl/dma_bus_arbiter_if.sv
// Bus-side signal bundle for dma_bus_arbiter: requests from timing/DMA control,
// halt/grant/kill back to the 6502 and DMA engine.
interface dma_bus_arbiter_if #(
  parameter int unsigned CNT_W = 10
);
  logic             enable;
  logic             line_start;
  logic             dma_req;
  logic             dma_done;
  logic             cpu_phase_end;
  logic             halt_b;
  logic             dma_grant;
  logic             dma_kill;
  logic [CNT_W-1:0] dma_cycles;
  logic             busy;

  modport master (
    output enable, line_start, dma_req, dma_done, cpu_phase_end,
    input  halt_b, dma_grant, dma_kill, dma_cycles, busy
  );

  modport slave (
    input  enable, line_start, dma_req, dma_done, cpu_phase_end,
    output halt_b, dma_grant, dma_kill, dma_cycles, busy
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Address-bus arbiter between the 6502 and Maria DMA: halts the CPU on a bus-cycle
// boundary, grants DMA, then releases after a turnaround. ATARI_DMA_BUDGET_EN enables budget kills.
module dma_bus_arbiter #(
  parameter int unsigned HALT_LATENCY   = 1,
  parameter int unsigned RELEASE_CYCLES = 2,
  parameter int unsigned DMA_BUDGET     = 420,
  parameter int unsigned CNT_W          = 10
) (
  input  logic             sysclk,
  input  logic             reset,
  dma_bus_arbiter_if.slave bus
);

  localparam int unsigned PH_W  = $clog2(HALT_LATENCY + 1);
  localparam int unsigned REL_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALT_LATENCY - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

`ifdef ATARI_DMA_BUDGET_EN
  localparam logic [CNT_W-1:0] BUDGET      = CNT_W'(DMA_BUDGET);
  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(DMA_BUDGET - 1);
  localparam logic [CNT_W-1:0] SAT_MAX     = BUDGET;
`else
  localparam logic [CNT_W-1:0] SAT_MAX     = '1;
`endif

  if (64'(DMA_BUDGET) >= (64'd1 << CNT_W)) begin : g_budget_check
    $error("DMA_BUDGET does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {IDLE, HALT_WAIT, GRANT, RELEASE} state_t;

  state_t             state_q, state_n;
  logic [PH_W-1:0]    phase_q, phase_n;
  logic [REL_W-1:0]   rel_q, rel_n;
  logic [CNT_W-1:0]   cycles_q, cycles_n;
  logic               kill_q, kill_n;
  logic               budget_spent;

`ifdef ATARI_DMA_BUDGET_EN
  assign budget_spent = (cycles_q == BUDGET);
`else
  assign budget_spent = 1'b0;
`endif

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      rel_q    <= '0;
      cycles_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      phase_q  <= phase_n;
      rel_q    <= rel_n;
      cycles_q <= cycles_n;
      kill_q   <= kill_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    phase_n  = phase_q;
    rel_n    = rel_q;
    kill_n   = 1'b0;
    cycles_n = cycles_q;
    if (state_q == GRANT && cycles_q != SAT_MAX) cycles_n = cycles_q + 1'b1;
    if (bus.line_start) cycles_n = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.dma_req && bus.enable && !budget_spent) begin
          state_n = HALT_WAIT;
          phase_n = '0;
        end
      end
      HALT_WAIT: begin
        if (!bus.dma_req || !bus.enable) begin
          state_n = IDLE;
        end else if (bus.cpu_phase_end) begin
          phase_n = phase_q + 1'b1;
          if (phase_q == PH_LAST) state_n = GRANT;
        end
      end
      GRANT: begin
        // done and enable-low exit quietly and take priority over any kill cause
        if (bus.dma_done || !bus.enable) begin
          state_n = RELEASE;
          rel_n   = '0;
        end
`ifdef ATARI_DMA_BUDGET_EN
        else if (bus.line_start || cycles_q == BUDGET_LAST) begin
          state_n = RELEASE;
          rel_n   = '0;
          kill_n  = 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (rel_q == REL_LAST) state_n = IDLE;
        else                   rel_n   = rel_q + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs: halt_b falls on HALT_WAIT entry, so grant can never rise with it
  assign bus.halt_b     = (state_q == IDLE);
  assign bus.dma_grant  = (state_q == GRANT);
  assign bus.busy       = (state_q != IDLE);
  assign bus.dma_kill   = kill_q;
  assign bus.dma_cycles = cycles_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter with a queue scoreboard of expected values;
// budget/kill checks follow the ATARI_DMA_BUDGET_EN build setting.
module tb_dma_bus_arbiter;
  localparam int unsigned CNT_W = 10;

  logic sysclk = 1'b0;
  logic reset;
  always #5 sysclk = ~sysclk;

  dma_bus_arbiter_if #(.CNT_W(CNT_W)) bus ();

  dma_bus_arbiter #(
    .HALT_LATENCY  (1),
    .RELEASE_CYCLES(2),
    .DMA_BUDGET    (420),
    .CNT_W         (CNT_W)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned kill_pulses = 0;
  int unsigned inv_viol = 0;
  int unsigned k0;
  logic        prev_halt = 1'b1;
  logic        prev_grant = 1'b0;

  // Kill pulse count and grant/halt invariants, sampled mid-cycle
  always @(negedge sysclk) begin
    if (bus.dma_kill === 1'b1) kill_pulses++;
    if (bus.dma_grant === 1'b1 && bus.halt_b !== 1'b0) inv_viol++;
    if (bus.dma_grant === 1'b1 && prev_grant === 1'b0 && prev_halt === 1'b1) inv_viol++;
    prev_halt  = bus.halt_b;
    prev_grant = bus.dma_grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic ticks(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic expect_val(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0h required=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [15:0] cyc();
    return 16'(bus.dma_cycles);
  endfunction

  task automatic grant_now();
    bus.dma_req = 1'b1;
    tick();
    bus.cpu_phase_end = 1'b1;
    tick();
    bus.cpu_phase_end = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.line_start = 1'b0;
    bus.dma_req = 1'b0;
    bus.dma_done = 1'b0;
    bus.cpu_phase_end = 1'b0;

    expect_val("rst_halt_b", 16'd1);
    expect_val("rst_grant", 16'd0);
    expect_val("rst_kill", 16'd0);
    expect_val("rst_cycles", 16'd0);
    expect_val("rst_busy", 16'd0);
    ticks(2);
    chk(16'(bus.halt_b)); chk(16'(bus.dma_grant)); chk(16'(bus.dma_kill)); chk(cyc()); chk(16'(bus.busy));

    // Basic grant with cpu_phase_end every 4 cycles
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.dma_req = 1'b1;
    expect_val("req_halt_b", 16'd0);
    expect_val("req_grant", 16'd0);
    tick();
    chk(16'(bus.halt_b)); chk(16'(bus.dma_grant));
    expect_val("wait_grant", 16'd0);
    ticks(3);
    chk(16'(bus.dma_grant));
    bus.cpu_phase_end = 1'b1;
    expect_val("phase_grant", 16'd1);
    expect_val("phase_halt", 16'd0);
    tick();
    chk(16'(bus.dma_grant)); chk(16'(bus.halt_b));
    bus.cpu_phase_end = 1'b0;
    expect_val("grant_cyc9", 16'd9);
    ticks(9);
    chk(cyc());
    bus.dma_done = 1'b1;
    bus.dma_req = 1'b0;
    expect_val("done_grant", 16'd0);
    expect_val("done_cycles", 16'd10);
    expect_val("done_halt", 16'd0);
    expect_val("done_kill", 16'd0);
    tick();
    chk(16'(bus.dma_grant)); chk(cyc()); chk(16'(bus.halt_b)); chk(16'(bus.dma_kill));
    bus.dma_done = 1'b0;
    expect_val("rel1_halt", 16'd0);
    tick();
    chk(16'(bus.halt_b));
    expect_val("rel2_halt", 16'd1);
    expect_val("rel2_busy", 16'd0);
    expect_val("rel2_cycles", 16'd10);
    tick();
    chk(16'(bus.halt_b)); chk(16'(bus.busy)); chk(cyc());

    // Request withdrawn in HALT_WAIT
    bus.dma_req = 1'b1;
    expect_val("wd_halt_fall", 16'd0);
    tick();
    chk(16'(bus.halt_b));
    bus.dma_req = 1'b0;
    expect_val("wd_halt_rise", 16'd1);
    expect_val("wd_grant", 16'd0);
    tick();
    chk(16'(bus.halt_b)); chk(16'(bus.dma_grant));

    bus.line_start = 1'b1;
    expect_val("ls_idle_cycles", 16'd0);
    tick();
    chk(cyc());
    bus.line_start = 1'b0;

    // Enable dropped mid-grant
    k0 = kill_pulses;
    grant_now();
    ticks(3);
    bus.enable = 1'b0;
    expect_val("en_grant", 16'd0);
    expect_val("en_halt", 16'd0);
    expect_val("en_cycles", 16'd4);
    tick();
    chk(16'(bus.dma_grant)); chk(16'(bus.halt_b)); chk(cyc());
    bus.enable = 1'b1;
    bus.dma_req = 1'b0;
    expect_val("en_release_halt", 16'd1);
    ticks(2);
    chk(16'(bus.halt_b));
    expect_val("en_no_kill", 16'd0);
    chk(16'(kill_pulses - k0));

    // Asynchronous reset mid-grant
    grant_now();
    ticks(2);
    expect_val("arst_halt", 16'd1);
    expect_val("arst_grant", 16'd0);
    expect_val("arst_cycles", 16'd0);
    #2;
    reset = 1'b1;
    #1;
    chk(16'(bus.halt_b)); chk(16'(bus.dma_grant)); chk(cyc());
    bus.dma_req = 1'b0;
    tick();
    reset = 1'b0;
    expect_val("arst_after_halt", 16'd1);
    tick();
    chk(16'(bus.halt_b));

`ifdef ATARI_DMA_BUDGET_EN
    // Budget exhaustion kill
    k0 = kill_pulses;
    grant_now();
    expect_val("bud_419", 16'd419);
    expect_val("bud_pre_kill", 16'd0);
    ticks(419);
    chk(cyc()); chk(16'(bus.dma_kill));
    expect_val("bud_kill", 16'd1);
    expect_val("bud_grant", 16'd0);
    expect_val("bud_cycles", 16'd420);
    tick();
    chk(16'(bus.dma_kill)); chk(16'(bus.dma_grant)); chk(cyc());
    expect_val("bud_kill_off", 16'd0);
    expect_val("bud_rel_halt", 16'd0);
    tick();
    chk(16'(bus.dma_kill)); chk(16'(bus.halt_b));
    expect_val("bud_halt_back", 16'd1);
    tick();
    chk(16'(bus.halt_b));
    expect_val("bud_one_pulse", 16'd1);
    chk(16'(kill_pulses - k0));

    // Request stays pending in IDLE while the budget is spent
    expect_val("bud_pending_halt", 16'd1);
    expect_val("bud_pending_busy", 16'd0);
    ticks(3);
    chk(16'(bus.halt_b)); chk(16'(bus.busy));
    bus.line_start = 1'b1;
    expect_val("bud_ls_cycles", 16'd0);
    expect_val("bud_ls_idle", 16'd1);
    tick();
    chk(cyc()); chk(16'(bus.halt_b));
    bus.line_start = 1'b0;
    expect_val("bud_rereq_halt", 16'd0);
    tick();
    chk(16'(bus.halt_b));
    bus.cpu_phase_end = 1'b1;
    expect_val("bud_regrant", 16'd1);
    tick();
    chk(16'(bus.dma_grant));
    bus.cpu_phase_end = 1'b0;

    // dma_done coinciding with exhaustion: no kill
    k0 = kill_pulses;
    expect_val("bud2_419", 16'd419);
    ticks(419);
    chk(cyc());
    bus.dma_done = 1'b1;
    bus.dma_req = 1'b0;
    expect_val("bud2_grant", 16'd0);
    expect_val("bud2_cycles", 16'd420);
    expect_val("bud2_kill", 16'd0);
    tick();
    chk(16'(bus.dma_grant)); chk(cyc()); chk(16'(bus.dma_kill));
    bus.dma_done = 1'b0;
    ticks(2);
    expect_val("bud2_no_kill", 16'd0);
    chk(16'(kill_pulses - k0));

    // line_start forced kill, then a normal re-grant
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    grant_now();
    ticks(5);
    bus.line_start = 1'b1;
    expect_val("lsk_kill", 16'd1);
    expect_val("lsk_cycles", 16'd0);
    expect_val("lsk_grant", 16'd0);
    expect_val("lsk_busy", 16'd1);
    tick();
    chk(16'(bus.dma_kill)); chk(cyc()); chk(16'(bus.dma_grant)); chk(16'(bus.busy));
    bus.line_start = 1'b0;
    bus.dma_req = 1'b0;
    expect_val("lsk_halt_back", 16'd1);
    ticks(2);
    chk(16'(bus.halt_b));
    expect_val("lsk_regrant", 16'd1);
    grant_now();
    chk(16'(bus.dma_grant));

    // dma_done with line_start in GRANT: clear, no kill
    ticks(3);
    k0 = kill_pulses;
    bus.dma_done = 1'b1;
    bus.line_start = 1'b1;
    bus.dma_req = 1'b0;
    expect_val("dl_cycles", 16'd0);
    expect_val("dl_grant", 16'd0);
    tick();
    chk(cyc()); chk(16'(bus.dma_grant));
    bus.dma_done = 1'b0;
    bus.line_start = 1'b0;
    ticks(2);
    expect_val("dl_no_kill", 16'd0);
    chk(16'(kill_pulses - k0));
`else
    // Long grant without budget enforcement
    k0 = kill_pulses;
    grant_now();
    expect_val("nb_cycles600", 16'd600);
    expect_val("nb_grant", 16'd1);
    ticks(600);
    chk(cyc()); chk(16'(bus.dma_grant));
    bus.line_start = 1'b1;
    expect_val("nb_ls_grant", 16'd1);
    expect_val("nb_ls_cycles", 16'd0);
    tick();
    chk(16'(bus.dma_grant)); chk(cyc());
    bus.line_start = 1'b0;
    bus.dma_done = 1'b1;
    bus.dma_req = 1'b0;
    expect_val("nb_done_grant", 16'd0);
    tick();
    chk(16'(bus.dma_grant));
    bus.dma_done = 1'b0;
    ticks(2);
    expect_val("nb_no_kill", 16'd0);
    chk(16'(kill_pulses - k0));
`endif

    expect_val("invariants", 16'd0);
    chk(16'(inv_viol));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
